// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad event kinds, scan states and key index helper
package keypad_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_kind_e;

    typedef enum logic [1:0] {
        DRIVE,
        SETTLE,
        SAMPLE,
        HELD
    } scan_state_e;

    function automatic int key_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad event stream (valid/ready, code, kind)
interface keypad_scanner_if #(
    parameter int CODE_W = 4
);
    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;
    logic [1:0]        evt_kind;

    modport master (output evt_valid, output evt_code, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_kind, output evt_ready);
endinterface

// File: rtl/keypad_evt_slot.sv
// rtl/keypad_evt_slot.sv - one-entry event holding register with sticky overrun
module keypad_evt_slot
    import keypad_pkg::*;
#(
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CODE_W-1:0] push_code,
    input  evt_kind_e         push_kind,
    input  logic              overrun_clr,
    output logic              overrun,
    keypad_scanner_if.master  evt
);
    logic pop;

    assign pop = evt.evt_valid && evt.evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_valid <= 1'b0;
            evt.evt_code  <= '0;
            evt.evt_kind  <= 2'd0;
            overrun       <= 1'b0;
        end else begin
            if (push && (!evt.evt_valid || pop)) begin
                evt.evt_valid <= 1'b1;
                evt.evt_code  <= push_code;
                evt.evt_kind  <= push_kind;
            end else if (pop) begin
                evt.evt_valid <= 1'b0;
            end
            // A dropped event outranks a clear arriving in the same cycle.
            if (push && evt.evt_valid && !pop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - ROWS x COLS keypad scanner with debounce, ghost rejection and repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SETTLE_CYC  = 2000,
    parameter int DEB_SAMPLES = 4,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 1000,
    parameter int REPEAT_PER  = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    keypad_scanner_if.master evt,
    output logic            overrun,
    input  logic            overrun_clr,
    output logic            ghost
);
    localparam int CODE_W  = $clog2(ROWS * COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int SET_W   = $clog2(SETTLE_CYC + 1);
    localparam int DEB_W   = $clog2(DEB_SAMPLES + 1);
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    scan_state_e       state;
    logic [COLS-1:0]   col_meta, col_sync, cols;
    logic [ROW_W-1:0]  row, row_next;
    logic [COL_W-1:0]  col_idx, cand;
    logic [SET_W-1:0]  settle_cnt;
    logic [DEB_W-1:0]  deb_cnt, deb_inc, rel_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              multi, settle_done;
    logic              push;
    logic [CODE_W-1:0] push_code, sample_code, held_code;
    evt_kind_e         push_kind;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        cols    = ~col_sync;
        col_idx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (cols[c]) col_idx = COL_W'(c);
        end
        multi       = (cols & (cols - COLS'(1))) != '0;
        row_next    = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
        settle_done = settle_cnt == SET_W'(SETTLE_CYC - 1);
        // deb_cnt==0 means no live candidate, so a stale cand from another row never matches.
        deb_inc     = (col_idx == cand && deb_cnt != '0) ? deb_cnt + DEB_W'(1) : DEB_W'(1);
        sample_code = CODE_W'(key_idx(int'(row), int'(col_idx), COLS));
        held_code   = CODE_W'(key_idx(int'(row), int'(cand), COLS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DRIVE;
            row        <= '0;
            row_n      <= '1;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            rel_cnt    <= '0;
            rep_cnt    <= '0;
            cand       <= '0;
            ghost      <= 1'b0;
            push       <= 1'b0;
            push_code  <= '0;
            push_kind  <= EVT_PRESS;
        end else begin
            ghost <= 1'b0;
            push  <= 1'b0;
            case (state)
                DRIVE: begin
                    row_n      <= ~(ROWS'(1) << row);
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_done) state <= SAMPLE;
                    else             settle_cnt <= settle_cnt + SET_W'(1);
                end
                SAMPLE: begin
                    settle_cnt <= '0;
                    if (cols == '0 || multi) begin
                        ghost   <= multi;
                        deb_cnt <= '0;
                        row     <= row_next;
                        state   <= DRIVE;
                    end else if (deb_inc == DEB_W'(DEB_SAMPLES)) begin
                        cand      <= col_idx;
                        deb_cnt   <= '0;
                        rel_cnt   <= '0;
                        rep_cnt   <= REP_W'(REPEAT_DLY);
                        push      <= 1'b1;
                        push_code <= sample_code;
                        push_kind <= EVT_PRESS;
                        state     <= HELD;
                    end else begin
                        cand    <= col_idx;
                        deb_cnt <= deb_inc;
                        state   <= SETTLE;
                    end
                end
                HELD: begin
                    if (!settle_done) begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end else begin
                        settle_cnt <= '0;
                        // Only the held column matters; other keys on this row are ignored.
                        if (col_sync[cand]) begin
                            if (rel_cnt == DEB_W'(DEB_SAMPLES - 1)) begin
                                rel_cnt   <= '0;
                                push      <= 1'b1;
                                push_code <= held_code;
                                push_kind <= EVT_RELEASE;
                                row       <= row_next;
                                state     <= DRIVE;
                            end else begin
                                rel_cnt <= rel_cnt + DEB_W'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                            if (REPEAT_EN != 0) begin
                                if (rep_cnt <= REP_W'(1)) begin
                                    rep_cnt   <= REP_W'(REPEAT_PER);
                                    push      <= 1'b1;
                                    push_code <= held_code;
                                    push_kind <= EVT_REPEAT;
                                end else begin
                                    rep_cnt <= rep_cnt - REP_W'(1);
                                end
                            end
                        end
                    end
                end
                default: state <= DRIVE;
            endcase
        end
    end

    keypad_evt_slot #(
        .CODE_W (CODE_W)
    ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_code   (push_code),
        .push_kind   (push_kind),
        .overrun_clr (overrun_clr),
        .overrun     (overrun),
        .evt         (evt)
    );
endmodule
